// File: rtl/mul_share_arb.sv
`timescale 1ns/1ps
// mul_share_arb
//   Round-robin arbiter/sequencer sharing one 8x8 signed sequential multiplier
//   (sign_mul, start/valid handshake) among NREQ requesters. One operation is
//   in flight at a time: grant -> start -> wait for valid (or watchdog) ->
//   return the product with the owner ID over a valid/ready channel.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid[i]    requester i has operands on req_x/req_y slice i
//   req_x, req_y    8-bit signed operands, slice i = [8*i +: 8]
//   req_ready[i]    one-cycle one-hot accept pulse
//   resp_*          result channel: id, 16-bit product, watchdog error flag
//   mul_start/x/y   drive the shared sign_mul
//   mul_z/valid     product and completion from sign_mul
module mul_share_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [15:0]       resp_z,
  output logic              resp_err,
  output logic              mul_start,
  output logic [7:0]        mul_x,
  output logic [7:0]        mul_y,
  input  logic [15:0]       mul_z,
  input  logic              mul_valid
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             mul_start_q, mul_start_d;
  logic [7:0]       mul_x_q, mul_x_d;
  logic [7:0]       mul_y_q, mul_y_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [15:0]      resp_z_q, resp_z_d;
  logic             resp_err_q, resp_err_d;
  logic             resp_valid_q, resp_valid_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;

  // First valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // The accept pulse must coincide with the cycle the operands are sampled,
  // so it is decoded from state rather than registered. Masking with rst keeps
  // it low while reset is held even if requests are pending.
  assign req_ready = (state_q == IDLE && gnt_found && !rst) ?
                     (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    wd_d         = wd_q;
    mul_start_d  = 1'b0;
    mul_x_d      = mul_x_q;
    mul_y_d      = mul_y_q;
    resp_id_d    = resp_id_q;
    resp_z_d     = resp_z_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          // Operands are captured once here and held until the next grant:
          // sign_mul keeps reading X across all of its iterations.
          mul_x_d     = req_x[{gnt_idx, 3'b000} +: 8];
          mul_y_d     = req_y[{gnt_idx, 3'b000} +: 8];
          resp_id_d   = gnt_idx;
          rr_d        = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          mul_start_d = 1'b1;            // high during ISSUE
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = BUSY;
      end
      BUSY: begin
        wd_d = wd_q + 1'b1;
        // mul_valid is checked first so it wins a same-cycle timeout.
        if (mul_valid) begin
          resp_z_d     = mul_z;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          resp_z_d     = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      wd_q         <= '0;
      mul_start_q  <= 1'b0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      resp_id_q    <= '0;
      resp_z_q     <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      wd_q         <= wd_d;
      mul_start_q  <= mul_start_d;
      mul_x_q      <= mul_x_d;
      mul_y_q      <= mul_y_d;
      resp_id_q    <= resp_id_d;
      resp_z_q     <= resp_z_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign mul_start  = mul_start_q;
  assign mul_x      = mul_x_q;
  assign mul_y      = mul_y_q;
  assign resp_id    = resp_id_q;
  assign resp_z     = resp_z_q;
  assign resp_err   = resp_err_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one sign_mul instance (8x8 signed sequential multiplier; start/valid handshake) between NREQ requesters.
- Accepts one operand pair at a time and holds the operands stable on the multiplier for the whole operation.
- Captures the 16-bit product and returns it with the requester ID over a valid/ready response channel.
- Includes a watchdog so a stuck multiplier cannot hang the requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to clog2(NREQ).
- TIMEOUT, 15, maximum cycles spent in BUSY waiting for mul_valid; must be at least 10.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- req_valid  in  NREQ  per-requester request.
- req_x  in  8*NREQ  signed multiplicand; slice i belongs to requester i.
- req_y  in  8*NREQ  signed multiplier operand; slice i belongs to requester i.
- req_ready  out  NREQ  one-hot grant/accept pulse.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  requester that owns the result.
- resp_z  out  16  signed product.
- resp_err  out  1  watchdog expired; resp_z is 0.
- mul_start  out  1  to sign_mul start.
- mul_x  out  8  to sign_mul X.
- mul_y  out  8  to sign_mul Y.
- mul_z  in  16  from sign_mul Z.
- mul_valid  in  1  from sign_mul valid.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_z=0, resp_err=0, mul_start=0, mul_x=0, mul_y=0. State=IDLE, rr pointer=0, watchdog=0.
- Reset mid-operation aborts the operation; no response is produced.
- sign_mul has its own active-low reset. It is driven externally as !rst.
- State machine: IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, grant the first requester with req_valid=1, searching from rr pointer upward with wrap.
  - Assert req_ready[g] for exactly this one cycle; the request transfers on req_valid&req_ready.
  - Latch req_x[g] into mul_x, req_y[g] into mul_y, and g into resp_id.
  - Set rr pointer = g+1 mod NREQ. Go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly one cycle.
  - Clear watchdog. Go to BUSY.
- BUSY:
  - mul_start=0. Watchdog increments each cycle.
  - On mul_valid=1: resp_z<=mul_z, resp_err<=0, go to RESP.
  - If watchdog reaches TIMEOUT first: resp_z<=0, resp_err<=1, go to RESP.
  - If both happen in the same cycle, mul_valid wins.
- RESP:
  - resp_valid=1. resp_id, resp_z and resp_err are held stable.
  - On resp_ready=1: go to IDLE; resp_valid drops next cycle.
- mul_x and mul_y change only in the IDLE grant cycle. They stay stable through ISSUE, BUSY and RESP, because sign_mul samples X bits during all iterations.
- mul_valid outside BUSY is ignored.
- req_ready is 0 in every state except IDLE.
- With sign_mul, mul_valid arrives 9 cycles after mul_start. Timing for an uncontended request accepted at cycle t, with resp_ready tied high:
  - mul_start at t+1.
  - mul_valid at t+10.
  - resp_valid at t+11.
  - Next grant at t+12.
  - Throughput: one operation per 12 cycles.
- Requesters must hold req_valid and operands until req_ready. A request dropped before grant is simply not served.
- The pointer advances only on a grant. Under full load every requester is served once per NREQ operations.

Test Plan:
1. Single request on requester 0, X=3, Y=-5 -> req_ready[0] pulse. mul_start one cycle later. resp_valid 11 cycles after the accept, with resp_z=0xFFF1, resp_id=0, resp_err=0.
2. All four requesters valid from reset, operands (i+1, 10) -> grants in order 0,1,2,3. resp_z = 10, 20, 30, 40. Consecutive grants are 12 cycles apart.
3. Grant requester 2, then requesters 0 and 3 both pending -> requester 3 is granted before 0. Then 0 is granted.
4. X=-100, Y=50 with resp_ready low for 5 cycles in RESP -> resp_valid, resp_z=0xEC78 and resp_id are held stable. No new req_ready appears until the cycle after resp_ready rises.
5. mul_valid forced low -> resp_err=1 and resp_z=0 after TIMEOUT cycles in BUSY. A late mul_valid is ignored, and the next request completes normally.
6. rst asserted mid-BUSY -> all outputs are 0 in the same cycle with no clock edge needed. After release, a new request on requester 1 is granted first.
